// File: rtl/sorcerer_ram_upload_if.sv
// Upload-side bus bundle: HPS ioctl read channel plus byte-wide RAM read port.
// master = hps_io / RAM arbiter side, slave = sorcerer_ram_upload.
interface sorcerer_ram_upload_if;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [15:0] ioctl_addr;
   logic [15:0] ioctl_din;
   logic        ioctl_wait;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_data;

   modport master (
      output ioctl_upload, ioctl_rd, ioctl_addr, mem_ack, mem_data,
      input  ioctl_din, ioctl_wait, mem_req, mem_addr
   );

   modport slave (
      input  ioctl_upload, ioctl_rd, ioctl_addr, mem_ack, mem_data,
      output ioctl_din, ioctl_wait, mem_req, mem_addr
   );
endinterface

// File: rtl/sorcerer_ram_upload.sv
// sorcerer_ram_upload: serves HPS upload read strobes by fetching two bytes
// from core RAM and returning them as a little-endian word on ioctl_din.
// Optional feature macro: SORCERER_UPLOAD_CKSUM_EN (running byte checksum on cksum_o).
module sorcerer_ram_upload #(
   parameter logic [7:0] PAD_BYTE = 8'hFF,
   parameter int         ACK_TMO  = 255
) (
   input  logic                        clk_sys,
   input  logic                        reset,
   sorcerer_ram_upload_if.slave        bus,
   input  logic [15:0]                 base_addr_i,
   input  logic [15:0]                 upload_len_i,
   output logic                        busy_o,
   output logic                        err_o,
   output logic [7:0]                  cksum_o
);

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

   // Last cycle count of a byte fetch before giving up on the ack.
   localparam logic [7:0] TMO_LAST = 8'(ACK_TMO - 1);

   state_t      state_q, state_d;
   logic        up_q;
   logic [15:0] len_q;
   logic [15:0] off_q;
   logic [7:0]  lo_q;
   logic [7:0]  tmo_q;
   logic [15:0] din_q;
   logic        err_q;

   logic        up_rise;
   logic        in_byte;
   logic [15:0] cur_off;
   logic        pad;
   logic        tmo_hit;
   logic        byte_done;
   logic [7:0]  byte_val;
   logic        accept;
   logic        req_c;

   // Word offset LSB is ignored: words are always even-aligned.
   logic unused_addr0;
   assign unused_addr0 = bus.ioctl_addr[0];

   assign up_rise   = bus.ioctl_upload & ~up_q;
   assign in_byte   = (state_q == S_LO) | (state_q == S_HI);
   assign cur_off   = (state_q == S_HI) ? (off_q + 16'd1) : off_q;
   // Offsets past the image never touch RAM.
   assign pad       = cur_off >= len_q;
   assign req_c     = in_byte & ~pad;
   assign tmo_hit   = req_c & ~bus.mem_ack & (tmo_q == TMO_LAST);
   assign byte_done = in_byte & (pad | bus.mem_ack | tmo_hit);
   assign byte_val  = (!pad && bus.mem_ack) ? bus.mem_data : PAD_BYTE;
   // DONE is the cycle the word is presented, so a new strobe there is taken
   // like one in IDLE to allow back-to-back reads.
   assign accept    = ((state_q == S_IDLE) | (state_q == S_DONE)) &
                      bus.ioctl_rd & bus.ioctl_upload;

   // FSM state register
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state: fetch low byte, then high byte, then present the word
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: state_d = accept ? S_LO : S_IDLE;
         S_LO: begin
            if (!bus.ioctl_upload) state_d = S_IDLE;
            else if (byte_done)    state_d = S_HI;
         end
         S_HI: begin
            if (!bus.ioctl_upload) state_d = S_IDLE;
            else if (byte_done)    state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: RAM request/address and handshake status
   always_comb begin
      bus.mem_req    = req_c;
      bus.mem_addr   = req_c ? (base_addr_i + cur_off) : 16'h0000;
      busy_o         = in_byte;
      bus.ioctl_wait = bus.ioctl_rd | in_byte;
      bus.ioctl_din  = din_q;
      err_o          = err_q;
   end

   // Upload session tracking: edge detect and length latch
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         up_q  <= 1'b0;
         len_q <= 16'h0000;
      end else begin
         up_q <= bus.ioctl_upload;
         if (up_rise) len_q <= upload_len_i;
      end
   end

   // Word datapath: offset latch, low byte hold, output word register
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         off_q <= 16'h0000;
         lo_q  <= 8'h00;
         din_q <= 16'h0000;
      end else begin
         if (accept) off_q <= {bus.ioctl_addr[15:1], 1'b0};
         if (state_q == S_LO && byte_done) lo_q <= byte_val;
         if (state_q == S_HI && byte_done && bus.ioctl_upload)
            din_q <= {byte_val, lo_q};
      end
   end

   // Ack timeout counter, restarted for every byte
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)                      tmo_q <= 8'h00;
      else if (!in_byte || byte_done) tmo_q <= 8'h00;
      else if (req_c)                 tmo_q <= tmo_q + 8'd1;
   end

   // Sticky error: ack timeout or strobe while busy; cleared per session
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)                             err_q <= 1'b0;
      else if (up_rise)                      err_q <= 1'b0;
      else if (tmo_hit || (bus.ioctl_rd && in_byte)) err_q <= 1'b1;
   end

`ifdef SORCERER_UPLOAD_CKSUM_EN
   logic [7:0] cks_q;

   // Running sum of every byte handed to the HPS, pad bytes included
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)        cks_q <= 8'h00;
      else if (up_rise) cks_q <= 8'h00;
      else if (state_q == S_HI && byte_done && bus.ioctl_upload)
         cks_q <= cks_q + byte_val + lo_q;
   end

   assign cksum_o = cks_q;
`else
   assign cksum_o = 8'h00;
`endif

endmodule

// File: tb/tb_sorcerer_ram_upload.sv
module tb_sorcerer_ram_upload;
   logic        clk_sys = 1'b0;
   logic        reset;
   logic [15:0] base_addr;
   logic [15:0] upload_len;
   logic        busy, err;
   logic [7:0]  cksum;
   int          checks   = 0;
   int          failures = 0;

`ifdef SORCERER_UPLOAD_CKSUM_EN
   localparam logic [7:0] EXP_CKS = 8'hAA;
`else
   localparam logic [7:0] EXP_CKS = 8'h00;
`endif

   sorcerer_ram_upload_if u_if();

   sorcerer_ram_upload dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .bus          (u_if.slave),
      .base_addr_i  (base_addr),
      .upload_len_i (upload_len),
      .busy_o       (busy),
      .err_o        (err),
      .cksum_o      (cksum)
   );

   always #5 clk_sys = ~clk_sys;

   // RAM model: ack after 'lat' request cycles, never when ack_en is low
   logic [7:0] ram [0:65535];
   int         lat    = 0;
   logic       ack_en = 1'b1;
   int         cnt    = 0;
   int         nacks  = 0;

   always_comb begin
      u_if.mem_ack  = u_if.mem_req && ack_en && (cnt == lat);
      u_if.mem_data = ram[u_if.mem_addr];
   end

   always @(posedge clk_sys) begin
      if (!u_if.mem_req || u_if.mem_ack) cnt <= 0;
      else                               cnt <= cnt + 1;
      if (u_if.mem_req && u_if.mem_ack)  nacks <= nacks + 1;
   end

   task automatic start_upload(input logic [15:0] base, input logic [15:0] len);
      @(negedge clk_sys);
      u_if.ioctl_upload = 1'b0;
      base_addr = base;
      upload_len = len;
      @(negedge clk_sys);
      u_if.ioctl_upload = 1'b1;
      @(negedge clk_sys);
   endtask

   // Strobe in the current cycle, then count cycles until wait drops.
   task automatic rd_now(input logic [15:0] a, output int cyc);
      u_if.ioctl_addr = a;
      u_if.ioctl_rd = 1'b1;
      @(negedge clk_sys);
      u_if.ioctl_rd = 1'b0;
      #1;
      cyc = 1;
      while (u_if.ioctl_wait && cyc < 2000) begin
         @(negedge clk_sys); #1;
         cyc++;
      end
      checks++;
      if (u_if.ioctl_wait !== 1'b0) begin
         failures++;
         $display("FAIL rd_timeout addr=%h wait still %b after %0d cycles, required 0", a, u_if.ioctl_wait, cyc);
      end
   endtask

   task automatic rd_word(input logic [15:0] a, output int cyc);
      @(negedge clk_sys);
      rd_now(a, cyc);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      u_if.ioctl_upload = 1'b0;
      u_if.ioctl_rd = 1'b0;
      u_if.ioctl_addr = 16'h0;
      base_addr = 16'h0;
      upload_len = 16'h0;
      repeat (3) @(negedge clk_sys);
      checks++;
      if ({u_if.ioctl_din, u_if.ioctl_wait, u_if.mem_req, u_if.mem_addr, busy, err, cksum} !== 51'h0) begin
         failures++;
         $display("FAIL reset din=%h wait=%b req=%b addr=%h busy=%b err=%b cks=%h, required all 0",
                  u_if.ioctl_din, u_if.ioctl_wait, u_if.mem_req, u_if.mem_addr, busy, err, cksum);
      end
      reset = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic test_basic;
      int cyc;
      lat = 0;
      start_upload(16'h1000, 16'd4);
      // First read traced cycle by cycle for latency and addresses.
      u_if.ioctl_addr = 16'h0000;
      u_if.ioctl_rd = 1'b1;
      #1;
      checks++;
      if (u_if.ioctl_wait !== 1'b1) begin failures++; $display("FAIL wait_T got %b, required 1", u_if.ioctl_wait); end
      @(negedge clk_sys);
      u_if.ioctl_rd = 1'b0;
      #1;
      checks++;
      if ({u_if.ioctl_wait, busy, u_if.mem_req, u_if.mem_addr} !== {3'b111, 16'h1000}) begin
         failures++;
         $display("FAIL T1 wait=%b busy=%b req=%b addr=%h, required 1 1 1 1000", u_if.ioctl_wait, busy, u_if.mem_req, u_if.mem_addr);
      end
      @(negedge clk_sys); #1;
      checks++;
      if ({u_if.ioctl_wait, u_if.mem_req, u_if.mem_addr} !== {2'b11, 16'h1001}) begin
         failures++;
         $display("FAIL T2 wait=%b req=%b addr=%h, required 1 1 1001", u_if.ioctl_wait, u_if.mem_req, u_if.mem_addr);
      end
      @(negedge clk_sys); #1;
      checks++;
      if ({u_if.ioctl_wait, u_if.ioctl_din} !== {1'b0, 16'h2211}) begin
         failures++;
         $display("FAIL T3 wait=%b din=%h, required 0 2211", u_if.ioctl_wait, u_if.ioctl_din);
      end
      rd_word(16'h0002, cyc);
      checks++;
      if ({u_if.ioctl_din, err, cksum} !== {16'h4433, 1'b0, EXP_CKS}) begin
         failures++;
         $display("FAIL word2 din=%h err=%b cks=%h, required 4433 0 %h", u_if.ioctl_din, err, cksum, EXP_CKS);
      end
   endtask

   task automatic test_pad;
      int cyc, n0;
      start_upload(16'h1000, 16'd3);
      n0 = nacks;
      rd_word(16'h0003, cyc);   // odd address treated as offset 2
      checks++;
      if (u_if.ioctl_din !== 16'hFF33 || nacks - n0 != 1) begin
         failures++;
         $display("FAIL pad din=%h acks=%0d, required ff33 1", u_if.ioctl_din, nacks - n0);
      end
   endtask

   task automatic test_latency5;
      int cyc;
      lat = 5;
      start_upload(16'h1000, 16'd4);
      rd_word(16'h0000, cyc);
      checks++;
      if (u_if.ioctl_din !== 16'h2211 || cyc != 13) begin
         failures++;
         $display("FAIL lat5 din=%h cyc=%0d, required 2211 13", u_if.ioctl_din, cyc);
      end
      lat = 0;
   endtask

   task automatic test_back_to_back;
      int cyc;
      lat = 0;
      start_upload(16'h1000, 16'd4);
      rd_word(16'h0000, cyc);
      rd_now(16'h0002, cyc);    // strobe in the DONE cycle of the previous word
      checks++;
      if (u_if.ioctl_din !== 16'h4433 || cyc != 3 || err !== 1'b0) begin
         failures++;
         $display("FAIL b2b din=%h cyc=%0d err=%b, required 4433 3 0", u_if.ioctl_din, cyc, err);
      end
   endtask

   task automatic test_busy_rd;
      int cyc;
      lat = 5;
      start_upload(16'h1000, 16'd4);
      rd_word(16'h0000, cyc);   // leave din at 2211 with no error
      @(negedge clk_sys);
      u_if.ioctl_addr = 16'h0000;
      u_if.ioctl_rd = 1'b1;
      @(negedge clk_sys);
      u_if.ioctl_rd = 1'b0;
      @(negedge clk_sys);
      u_if.ioctl_addr = 16'h0002;
      u_if.ioctl_rd = 1'b1;     // stray strobe while busy
      @(negedge clk_sys);
      u_if.ioctl_rd = 1'b0;
      #1;
      cyc = 3;
      while (u_if.ioctl_wait && cyc < 2000) begin @(negedge clk_sys); #1; cyc++; end
      checks++;
      if (u_if.ioctl_din !== 16'h2211 || err !== 1'b1 || cyc != 13) begin
         failures++;
         $display("FAIL busy_rd din=%h err=%b cyc=%0d, required 2211 1 13", u_if.ioctl_din, err, cyc);
      end
      lat = 0;
   endtask

   task automatic test_abort;
      lat = 5;
      start_upload(16'h1000, 16'd4);
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL err_clear got %b, required 0", err); end
      u_if.ioctl_addr = 16'h0002;
      u_if.ioctl_rd = 1'b1;
      @(negedge clk_sys);
      u_if.ioctl_rd = 1'b0;
      @(negedge clk_sys);       // in LO, request pending
      u_if.ioctl_upload = 1'b0;
      @(negedge clk_sys); #1;
      checks++;
      if ({u_if.mem_req, busy, u_if.ioctl_din} !== {2'b00, 16'h2211}) begin
         failures++;
         $display("FAIL abort req=%b busy=%b din=%h, required 0 0 2211", u_if.mem_req, busy, u_if.ioctl_din);
      end
      u_if.ioctl_rd = 1'b1;     // strobe with upload low
      @(negedge clk_sys);
      u_if.ioctl_rd = 1'b0;
      @(negedge clk_sys); #1;
      checks++;
      if ({busy, u_if.mem_req, err, u_if.ioctl_wait} !== 4'b0000) begin
         failures++;
         $display("FAIL rd_noupload busy=%b req=%b err=%b wait=%b, required 0 0 0 0", busy, u_if.mem_req, err, u_if.ioctl_wait);
      end
      lat = 0;
   endtask

   task automatic test_timeout;
      int cyc;
      ack_en = 1'b0;
      start_upload(16'h1000, 16'd4);
      rd_word(16'h0000, cyc);
      checks++;
      if (u_if.ioctl_din !== 16'hFFFF || err !== 1'b1 || cyc != 511) begin
         failures++;
         $display("FAIL timeout din=%h err=%b cyc=%0d, required ffff 1 511", u_if.ioctl_din, err, cyc);
      end
      ack_en = 1'b1;
      start_upload(16'h1000, 16'd4);
      checks++;
      if (err !== 1'b0 || cksum !== 8'h00) begin
         failures++;
         $display("FAIL tmo_clear err=%b cks=%h, required 0 00", err, cksum);
      end
   endtask

   task automatic test_len0;
      int cyc, n0;
      start_upload(16'h1000, 16'd0);
      n0 = nacks;
      rd_word(16'h0004, cyc);
      checks++;
      if (u_if.ioctl_din !== 16'hFFFF || nacks != n0 || cyc != 3) begin
         failures++;
         $display("FAIL len0 din=%h acks=%0d cyc=%0d, required ffff 0 3", u_if.ioctl_din, nacks - n0, cyc);
      end
   endtask

   task automatic test_wrap;
      lat = 0;
      start_upload(16'hFFFF, 16'd2);
      u_if.ioctl_addr = 16'h0000;
      u_if.ioctl_rd = 1'b1;
      @(negedge clk_sys);
      u_if.ioctl_rd = 1'b0;
      #1;
      checks++;
      if (u_if.mem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_lo addr=%h, required ffff", u_if.mem_addr); end
      @(negedge clk_sys); #1;
      checks++;
      if (u_if.mem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_hi addr=%h, required 0000", u_if.mem_addr); end
      @(negedge clk_sys); #1;
      checks++;
      if (u_if.ioctl_din !== 16'hA55A || u_if.ioctl_wait !== 1'b0) begin
         failures++;
         $display("FAIL wrap_din din=%h wait=%b, required a55a 0", u_if.ioctl_din, u_if.ioctl_wait);
      end
   endtask

   initial begin
      ram[16'h1000] = 8'h11;
      ram[16'h1001] = 8'h22;
      ram[16'h1002] = 8'h33;
      ram[16'h1003] = 8'h44;
      ram[16'hFFFF] = 8'h5A;
      ram[16'h0000] = 8'hA5;
      test_reset;
      test_basic;
      test_pad;
      test_latency5;
      test_back_to_back;
      test_busy_rd;
      test_abort;
      test_timeout;
      test_len0;
      test_wrap;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
